// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle ROM requester: strided fetch per FFT stage, fixed-latency capture,
// and a credit-protected show-ahead buffer feeding the butterfly stream.
module twiddle_fetch_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] stage_base,
    input  logic [ADDR_W-1:0] stage_stride,
    input  logic [LEN_W-1:0]  stage_len,
    output logic              busy,
    output logic              done,
    output logic              rom_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data [2:0],
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [DATA_W-1:0] tw_data [2:0],
    output logic              tw_last
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_acc;
    logic [ADDR_W-1:0]   stride_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    k_q;
    logic                rom_last;

    logic [ROM_LAT-1:0]  sr_valid;
    logic [ROM_LAT-1:0]  sr_last;
    logic [CNT_W-1:0]    inflight;

    logic [DATA_W-1:0]   mem_data [FIFO_DEPTH][3];
    logic                mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    fifo_count_nxt;

    logic                push;
    logic                pop;
    logic                credit_ok;
    logic                issue;
    logic                issue_last;

    // Credit check counts every request not yet written into the buffer
    always_comb begin
        push       = sr_valid[ROM_LAT-1];
        pop        = tw_valid & tw_ready;
        credit_ok  = (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH));
        issue      = (state == S_ISSUE) && credit_ok;
        issue_last = (k_q == (len_q - LEN_W'(1)));
    end

    // Stage sequencing, address accumulation and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_acc  <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            k_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_valid <= 1'b0;
            rom_addr  <= '0;
            rom_last  <= 1'b0;
        end else begin
            rom_valid <= 1'b0;
            rom_last  <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_acc <= stage_base;
                        stride_q <= stage_stride;
                        len_q    <= stage_len;
                        k_q      <= '0;
                        busy     <= 1'b1;
                        state    <= (stage_len == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (credit_ok) begin
                        rom_valid <= 1'b1;
                        rom_addr  <= addr_acc;
                        rom_last  <= issue_last;
                        addr_acc  <= addr_acc + stride_q;
                        k_q       <= k_q + LEN_W'(1);
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((inflight == '0) && pop && tw_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // Zero-length stages arrive here with done low and pulse it now
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latency tracker aligned with ROM output, plus outstanding-request counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_valid <= '0;
            sr_last  <= '0;
            inflight <= '0;
        end else begin
            sr_valid <= ROM_LAT'({sr_valid, rom_valid});
            sr_last  <= ROM_LAT'({sr_last, rom_last});
            case ({issue, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Buffer occupancy after this cycle's push/pop
    always_comb begin
        fifo_count_nxt = fifo_count;
        if (push && !pop) begin
            fifo_count_nxt = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_nxt = fifo_count - CNT_W'(1);
        end
    end

    // Return buffer storage, pointers and registered non-empty flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                for (int j = 0; j < 3; j++) begin
                    mem_data[i][j] <= '0;
                end
                mem_last[i] <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tw_valid   <= 1'b0;
        end else begin
            if (push) begin
                for (int j = 0; j < 3; j++) begin
                    mem_data[wr_ptr][j] <= rom_data[j];
                end
                mem_last[wr_ptr] <= sr_last[ROM_LAT-1];
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count_nxt;
            tw_valid   <= (fifo_count_nxt != '0);
        end
    end

    // Show-ahead head entry
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            tw_data[j] = mem_data[rd_ptr][j];
        end
        tw_last = mem_last[rd_ptr];
    end

    // The credit rule must keep a push from ever landing on a full buffer
    always @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (fifo_count < CNT_W'(FIFO_DEPTH))
            else $error("twiddle_fetch_ctrl: return buffer overflow");
        end
    end

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Scoreboarded bench for twiddle_fetch_ctrl with a behavioural one-cycle ROM.
module tb_twiddle_fetch_ctrl;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned LEN_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] stage_base;
    logic [ADDR_W-1:0] stage_stride;
    logic [LEN_W-1:0]  stage_len;
    logic              busy;
    logic              done;
    logic              rom_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data [2:0];
    logic              tw_valid;
    logic              tw_ready;
    logic [DATA_W-1:0] tw_data [2:0];
    logic              tw_last;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issue_cnt, tw_cnt, done_cnt;
    int first_issue, first_tw, last_hs, done_cyc, start_cyc;

    int exp_addr_q[$];
    int exp_word_q[$];
    bit exp_last_q[$];

    twiddle_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stage_base   (stage_base),
        .stage_stride (stage_stride),
        .stage_len    (stage_len),
        .busy         (busy),
        .done         (done),
        .rom_valid    (rom_valid),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .tw_valid     (tw_valid),
        .tw_ready     (tw_ready),
        .tw_data      (tw_data),
        .tw_last      (tw_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DATA_W-1:0] rom_word(input int addr, input int idx);
        logic [31:0] w;
        w = 32'(addr) ^ (32'(idx) << 20) ^ 32'hC3A5_0000;
        return {8{w}};
    endfunction

    // ROM model: registers its output on a valid read
    always @(posedge clk) begin
        if (rom_valid) begin
            for (int i = 0; i < 3; i++) rom_data[i] <= rom_word(int'(rom_addr), i);
        end
    end

    // Scoreboard monitor: compares every issue and every handshake against the queues
    always @(negedge clk) begin
        int  ea, ew;
        bit  el, bad;
        if (rst_n) begin
            if (rom_valid) begin
                issue_cnt++;
                if (first_issue < 0) first_issue = cyc;
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rom_addr: unexpected issue at addr %0d, required no issue", rom_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (rom_addr !== ADDR_W'(ea)) begin
                        n_fail++;
                        $display("FAIL rom_addr: got %0d, required %0d", rom_addr, ea);
                    end
                end
            end
            if (tw_valid && tw_ready) begin
                tw_cnt++;
                if (first_tw < 0) first_tw = cyc;
                if (tw_last) last_hs = cyc;
                n_checks++;
                if (exp_word_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tw_word: unexpected word, required none");
                end else begin
                    ew  = exp_word_q.pop_front();
                    el  = exp_last_q.pop_front();
                    bad = 1'b0;
                    for (int i = 0; i < 3; i++) if (tw_data[i] !== rom_word(ew, i)) bad = 1'b1;
                    if (tw_last !== el) bad = 1'b1;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL tw_word: word %0d last=%0b data0=%h, required addr %0d last=%0b data0=%h",
                                 tw_cnt, tw_last, tw_data[0][31:0], ew, el, rom_word(ew, 0) & 256'hFFFF_FFFF);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input int b, input int s, input int l, input bit fresh);
        @(posedge clk); #1;
        if (fresh) begin
            issue_cnt = 0; tw_cnt = 0; done_cnt = 0;
            first_issue = -1; first_tw = -1; last_hs = -1; done_cyc = -1;
            for (int k = 0; k < l; k++) begin
                exp_addr_q.push_back((b + k * s) % (1 << ADDR_W));
                exp_word_q.push_back((b + k * s) % (1 << ADDR_W));
                exp_last_q.push_back(k == l - 1);
            end
        end
        stage_base   = ADDR_W'(b);
        stage_stride = ADDR_W'(s);
        stage_len    = LEN_W'(l);
        start        = 1'b1;
        if (fresh) start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; tw_ready = 1'b0;
        stage_base = '0; stage_stride = '0; stage_len = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, rom_valid, tw_valid, tw_last, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b rv=%b tv=%b tl=%b addr=%0d, required all 0",
                     busy, done, rom_valid, tw_valid, tw_last, rom_addr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, tw_valid, rom_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b tv=%b rv=%b, required 000", busy, tw_valid, rom_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        tw_ready = 1'b1;
        launch(0, 1, 4, 1'b1);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy); end
        wait_done(60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done: got no done, required done"); end
        n_checks++;
        if (issue_cnt != 4 || tw_cnt != 4) begin
            n_fail++; $display("FAIL basic_count: issues=%0d words=%0d, required 4/4", issue_cnt, tw_cnt);
        end
        n_checks++;
        if (first_tw != first_issue + 2) begin
            n_fail++; $display("FAIL basic_latency: first tw at %0d, required %0d", first_tw, first_issue + 2);
        end
        n_checks++;
        if (done_cyc != last_hs + 1) begin
            n_fail++; $display("FAIL basic_done_timing: done at %0d, required %0d", done_cyc, last_hs + 1);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_after: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        tw_ready = 1'b0;
        launch(10, 1, 8, 1'b1);
        repeat (12) @(negedge clk);
        n_checks++;
        if (issue_cnt != 4 || tw_cnt != 0 || tw_valid !== 1'b1 || rom_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: issues=%0d words=%0d tv=%b rv=%b, required 4/0/1/0",
                     issue_cnt, tw_cnt, tw_valid, rom_valid);
        end
        @(posedge clk); #1 tw_ready = 1'b1;
        wait_done(100, ok);
        n_checks++;
        if (!ok || issue_cnt != 8 || tw_cnt != 8) begin
            n_fail++; $display("FAIL bp_release: done=%b issues=%0d words=%0d, required 1/8/8", ok, issue_cnt, tw_cnt);
        end
        n_checks++;
        if (exp_addr_q.size() != 0 || exp_word_q.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: %0d addrs %0d words left, required 0/0", exp_addr_q.size(), exp_word_q.size());
        end
    endtask

    task automatic test_wrap_stride();
        bit ok;
        tw_ready = 1'b1;
        launch(2046, 1, 4, 1'b1);
        wait_done(60, ok);
        n_checks++;
        if (!ok || issue_cnt != 4 || tw_cnt != 4) begin
            n_fail++; $display("FAIL wrap_count: done=%b issues=%0d words=%0d, required 1/4/4", ok, issue_cnt, tw_cnt);
        end
        launch(5, 16, 3, 1'b1);
        wait_done(60, ok);
        n_checks++;
        if (!ok || issue_cnt != 3 || tw_cnt != 3) begin
            n_fail++; $display("FAIL stride_count: done=%b issues=%0d words=%0d, required 1/3/3", ok, issue_cnt, tw_cnt);
        end
    endtask

    task automatic test_edge_len();
        bit ok;
        tw_ready = 1'b1;
        launch(7, 1, 0, 1'b1);
        wait_done(20, ok);
        n_checks++;
        if (!ok || done_cyc != start_cyc + 2 || issue_cnt != 0 || tw_cnt != 0) begin
            n_fail++;
            $display("FAIL len0: done=%b done_cyc=%0d issues=%0d words=%0d, required 1/%0d/0/0",
                     ok, done_cyc, issue_cnt, tw_cnt, start_cyc + 2);
        end
        launch(9, 3, 1, 1'b1);
        wait_done(30, ok);
        n_checks++;
        if (!ok || issue_cnt != 1 || tw_cnt != 1) begin
            n_fail++; $display("FAIL len1: done=%b issues=%0d words=%0d, required 1/1/1", ok, issue_cnt, tw_cnt);
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        tw_ready = 1'b1;
        launch(100, 2, 6, 1'b1);
        repeat (2) @(posedge clk);
        launch(500, 7, 3, 1'b0);
        wait_done(80, ok);
        n_checks++;
        if (!ok || issue_cnt != 6 || tw_cnt != 6) begin
            n_fail++; $display("FAIL busy_start: done=%b issues=%0d words=%0d, required 1/6/6", ok, issue_cnt, tw_cnt);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt != 1 || issue_cnt != 6 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_quiet: dones=%0d issues=%0d busy=%b, required 1/6/0", done_cnt, issue_cnt, busy);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        ok = 1'b0;
        launch(3, 5, 20, 1'b1);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            tw_ready = 1'($urandom_range(0, 1));
            if (done_cnt != 0) begin ok = 1'b1; break; end
        end
        tw_ready = 1'b1;
        n_checks++;
        if (!ok || issue_cnt != 20 || tw_cnt != 20) begin
            n_fail++; $display("FAIL random_ready: done=%b issues=%0d words=%0d, required 1/20/20", ok, issue_cnt, tw_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 1'b0;
        tw_ready = 1'b1;
        launch(40, 1, 8, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (issue_cnt >= 2) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_issue: issues=%0d, required >=2", issue_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, rom_valid, tw_valid, tw_last, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: busy=%b done=%b rv=%b tv=%b tl=%b addr=%0d, required all 0",
                     busy, done, rom_valid, tw_valid, tw_last, rom_addr);
        end
        exp_addr_q.delete(); exp_word_q.delete(); exp_last_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (tw_valid !== 1'b0 || rom_valid !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet: tv=%b rv=%b, required 0/0", tw_valid, rom_valid);
            end
        end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done: dones=%0d, required 0", done_cnt); end
        launch(0, 1, 4, 1'b1);
        wait_done(60, ok);
        n_checks++;
        if (!ok || issue_cnt != 4 || tw_cnt != 4) begin
            n_fail++; $display("FAIL rstmid_restart: done=%b issues=%0d words=%0d, required 1/4/4", ok, issue_cnt, tw_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_stride();
        test_edge_len();
        test_start_busy();
        test_random_ready();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
